// File: rtl/oam_port_if.sv
// CPU register bus, OAM DMA byte stream and sprite-evaluation read port of the PPU OAM.
// The master side is the CPU/DMA/PPU-timing logic. The slave side is the OAM itself.
interface oam_port_if;
  logic       cpu_en;
  logic       stop;
  logic       reg_we;
  logic       reg_re;
  logic [2:0] reg_sel;
  logic [7:0] reg_wdata;
  logic       dma_write;
  logic [7:0] dma_data;
  logic       rendering;
  logic       oamaddr_clear;
  logic       eval_re;
  logic [7:0] eval_addr;
  logic [7:0] eval_data;
  logic [7:0] rdata;
  logic [7:0] oamaddr;

  modport master (
    output cpu_en, stop, reg_we, reg_re, reg_sel, reg_wdata, dma_write, dma_data,
           rendering, oamaddr_clear, eval_re, eval_addr,
    input  eval_data, rdata, oamaddr
  );

  modport slave (
    input  cpu_en, stop, reg_we, reg_re, reg_sel, reg_wdata, dma_write, dma_data,
           rendering, oamaddr_clear, eval_re, eval_addr,
    output eval_data, rdata, oamaddr
  );
endinterface

// File: rtl/oam_port.sv
// 256x8 sprite OAM with OAMADDR/OAMDATA register access, DMA fill and a registered
// sprite-evaluation read port. The array is one write port and two synchronous reads.
module oam_port #(
  parameter logic [7:0] ATTR_MASK = 8'hE3
) (
  input logic       clk,
  input logic       reset,
  oam_port_if.slave bus
);
  localparam logic [2:0] SEL_OAMADDR = 3'd3;
  localparam logic [2:0] SEL_OAMDATA = 3'd4;

  logic [7:0] mem [256];
  logic [7:0] addr_q;
  logic [7:0] rdata_q;
  logic [7:0] eval_q;

  logic       upd;
  logic       cpu_addr_wr;
  logic       cpu_data_wr;
  logic       cpu_data_rd;
  logic       wr_evt;
  logic       store;
  logic [7:0] wr_byte;
  logic [7:0] addr_step;
  logic [7:0] rd_mask;

  assign upd         = bus.cpu_en & ~bus.stop;
  assign cpu_addr_wr = bus.reg_we && (bus.reg_sel == SEL_OAMADDR);
  assign cpu_data_wr = bus.reg_we && (bus.reg_sel == SEL_OAMDATA);
  assign cpu_data_rd = bus.reg_re && (bus.reg_sel == SEL_OAMDATA);

  // DMA owns the write slot; a colliding CPU OAMDATA write is dropped, not queued.
  assign wr_evt    = bus.dma_write | cpu_data_wr;
  assign wr_byte   = bus.dma_write ? bus.dma_data : bus.reg_wdata;
  assign store     = upd & wr_evt & ~bus.rendering & ~reset;
  // While rendering, a write only bumps the sprite index, keeping the byte offset.
  assign addr_step = bus.rendering ? 8'd4 : 8'd1;
  assign rd_mask   = (addr_q[1:0] == 2'd2) ? ATTR_MASK : 8'hFF;

  // NOTE: the OAM array is never reset so it maps onto block RAM; its contents
  // are undefined after power-up, and sequential state always uses <= so every
  // read below sees the pre-write byte on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (store) mem[addr_q] <= wr_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= 8'h00;
      rdata_q <= 8'h00;
      eval_q  <= 8'h00;
    end else begin
      if (upd) begin
        if (bus.oamaddr_clear) addr_q <= 8'h00;
        else if (wr_evt)       addr_q <= addr_q + addr_step;
        else if (cpu_addr_wr)  addr_q <= bus.reg_wdata;

        if (cpu_data_rd) rdata_q <= bus.rendering ? eval_q : (mem[addr_q] & rd_mask);
      end
      // Evaluation runs at PPU rate, so only the global stall holds it.
      if (!bus.stop && bus.eval_re) eval_q <= mem[bus.eval_addr];
    end
  end

  assign bus.oamaddr   = addr_q;
  assign bus.rdata     = rdata_q;
  assign bus.eval_data = eval_q;
endmodule

// File: tb/tb_oam_port.sv
// Scoreboard bench for oam_port: stimulus updates a behavioural OAM model and queues
// expected outputs; a negedge monitor pops and compares them against the DUT.
module tb_oam_port;
  logic clk = 1'b0;
  logic reset;

  oam_port_if bus ();

  oam_port #(.ATTR_MASK(8'hE3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, st, we, re;
    logic [2:0] sel;
    logic [7:0] wd;
    logic       dw;
    logic [7:0] dd;
    logic       rend, clr, ere;
    logic [7:0] ea;
  } stim_t;

  typedef enum int {K_ADDR, K_RDATA, K_EVAL} kind_t;

  typedef struct {
    int         due;
    kind_t      kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic [7:0] m_mem   [256];
  bit         m_known [256];
  logic [7:0] m_addr, m_rdata, m_eval;
  bit         m_rdata_k, m_eval_k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input kind_t kind, input string name, input logic [7:0] v);
    exp_t e;
    e.due  = cyc;
    e.kind = kind;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  exp_t       mon_e;
  logic [7:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_ADDR:  mon_act = bus.oamaddr;
        K_RDATA: mon_act = bus.rdata;
        default: mon_act = bus.eval_data;
      endcase
      checks++;
      if (mon_e.due != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d reached monitor late at cycle %0d",
                 mon_e.name, mon_e.due, cyc);
      end else if (mon_act !== mon_e.val) begin
        failures++;
        $display("FAIL %s @cycle %0d: got %h expected %h", mon_e.name, cyc, mon_act, mon_e.val);
      end
    end
  end

  function automatic stim_t quiet();
    stim_t s;
    s    = '{default: '0};
    s.en = 1'b1;
    return s;
  endfunction

  function automatic stim_t f_addr(input logic [7:0] v, input logic rend);
    stim_t s = quiet();
    s.we = 1'b1; s.sel = 3'd3; s.wd = v; s.rend = rend;
    return s;
  endfunction

  function automatic stim_t f_data(input logic [7:0] v, input logic rend);
    stim_t s = quiet();
    s.we = 1'b1; s.sel = 3'd4; s.wd = v; s.rend = rend;
    return s;
  endfunction

  function automatic stim_t f_dma(input logic [7:0] v);
    stim_t s = quiet();
    s.dw = 1'b1; s.dd = v;
    return s;
  endfunction

  function automatic stim_t f_read(input logic rend);
    stim_t s = quiet();
    s.re = 1'b1; s.sel = 3'd4; s.rend = rend;
    return s;
  endfunction

  function automatic stim_t f_eval(input logic [7:0] a);
    stim_t s = quiet();
    s.ere = 1'b1; s.ea = a;
    return s;
  endfunction

  // Drive one clock of inputs, advance the model by the register rules, queue expectations.
  task automatic step(input stim_t s);
    bit         upd, w;
    logic [7:0] b, n_addr, n_rdata, n_eval;
    bit         n_rk, n_ek;

    reset             = s.rst;
    bus.cpu_en        = s.en;
    bus.stop          = s.st;
    bus.reg_we        = s.we;
    bus.reg_re        = s.re;
    bus.reg_sel       = s.sel;
    bus.reg_wdata     = s.wd;
    bus.dma_write     = s.dw;
    bus.dma_data      = s.dd;
    bus.rendering     = s.rend;
    bus.oamaddr_clear = s.clr;
    bus.eval_re       = s.ere;
    bus.eval_addr     = s.ea;

    upd = s.en && !s.st;
    w   = s.dw || (s.we && s.sel == 3'd4);
    b   = s.dw ? s.dd : s.wd;

    n_addr = m_addr; n_rdata = m_rdata; n_rk = m_rdata_k; n_eval = m_eval; n_ek = m_eval_k;
    if (upd && s.re && s.sel == 3'd4) begin
      if (s.rend) begin
        n_rdata = m_eval;
        n_rk    = m_eval_k;
      end else begin
        n_rdata = m_mem[m_addr];
        if (m_addr % 4 == 2) n_rdata = n_rdata & 8'hE3;
        n_rk = m_known[m_addr];
      end
    end
    if (!s.st && s.ere) begin
      n_eval = m_mem[s.ea];
      n_ek   = m_known[s.ea];
    end
    if (upd) begin
      if (s.clr)                          n_addr = 8'h00;
      else if (w)                         n_addr = 8'((m_addr + (s.rend ? 4 : 1)) % 256);
      else if (s.we && s.sel == 3'd3)     n_addr = s.wd;
    end
    if (s.rst) begin
      n_addr = 8'h00; n_rdata = 8'h00; n_eval = 8'h00; n_rk = 1'b1; n_ek = 1'b1;
    end else if (upd && w && !s.rend) begin
      m_mem[m_addr]   = b;
      m_known[m_addr] = 1'b1;
    end
    m_addr = n_addr; m_rdata = n_rdata; m_rdata_k = n_rk; m_eval = n_eval; m_eval_k = n_ek;

    @(posedge clk);
    #1;
    push(K_ADDR, "oamaddr", m_addr);
    if (m_rdata_k) push(K_RDATA, "rdata", m_rdata);
    if (m_eval_k)  push(K_EVAL, "eval_data", m_eval);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    m_addr = 8'h00; m_rdata = 8'h00; m_eval = 8'h00; m_rdata_k = 1'b0; m_eval_k = 1'b0;

    reset = 1'b1;
    bus.cpu_en = 1'b0; bus.stop = 1'b0; bus.reg_we = 1'b0; bus.reg_re = 1'b0;
    bus.reg_sel = 3'd0; bus.reg_wdata = 8'h00; bus.dma_write = 1'b0; bus.dma_data = 8'h00;
    bus.rendering = 1'b0; bus.oamaddr_clear = 1'b0; bus.eval_re = 1'b0; bus.eval_addr = 8'h00;
    @(posedge clk); #1;

    // Reset state
    s = quiet(); s.rst = 1'b1;
    step(s);
    push(K_ADDR, "reset_oamaddr", 8'h00);
    push(K_RDATA, "reset_rdata", 8'h00);
    push(K_EVAL, "reset_eval", 8'h00);

    // CPU OAMDATA writes and attribute-masked readback
    step(f_addr(8'h10, 1'b0));
    step(f_data(8'hAA, 1'b0));
    step(f_data(8'hBB, 1'b0));
    step(f_data(8'hCC, 1'b0));
    step(f_data(8'hDD, 1'b0));
    push(K_ADDR, "cpu_wr_addr14", 8'h14);
    step(f_addr(8'h12, 1'b0));
    step(f_read(1'b0));
    push(K_RDATA, "attr_read_C0", 8'hC0);
    push(K_ADDR, "read_keeps_addr", 8'h12);
    step(f_eval(8'h10));
    push(K_EVAL, "eval_10_AA", 8'hAA);

    // Full 256-byte DMA from 0
    step(f_addr(8'h00, 1'b0));
    for (int i = 0; i < 256; i++) step(f_dma(8'(i)));
    push(K_ADDR, "dma256_addr00", 8'h00);
    step(f_eval(8'h7F));
    push(K_EVAL, "eval_7F", 8'h7F);

    // DMA wrap past FF
    step(f_addr(8'hFE, 1'b0));
    step(f_dma(8'h01));
    step(f_dma(8'h02));
    step(f_dma(8'h03));
    push(K_ADDR, "wrap_addr01", 8'h01);
    step(f_eval(8'hFE)); push(K_EVAL, "wrap_FE", 8'h01);
    step(f_eval(8'hFF)); push(K_EVAL, "wrap_FF", 8'h02);
    step(f_eval(8'h00)); push(K_EVAL, "wrap_00", 8'h03);

    // Rendering write: no store, +4 keeps low bits; clear beats OAMADDR write
    step(f_addr(8'hFD, 1'b1));
    step(f_data(8'h55, 1'b1));
    push(K_ADDR, "render_wr_addr01", 8'h01);
    step(f_eval(8'hFD));
    push(K_EVAL, "render_no_store", 8'hFD);
    s = f_addr(8'h40, 1'b1); s.clr = 1'b1;
    step(s);
    push(K_ADDR, "clear_beats_addr_wr", 8'h00);

    // Rendering read returns eval_data
    step(f_eval(8'h41));
    step(f_read(1'b1));
    push(K_RDATA, "render_read_eval", 8'h41);

    // DMA beats same-cycle CPU write; stop freezes a DMA write
    step(f_addr(8'h20, 1'b0));
    s = f_dma(8'h77); s.we = 1'b1; s.sel = 3'd4; s.wd = 8'h99;
    step(s);
    push(K_ADDR, "collide_addr21", 8'h21);
    step(f_eval(8'h20));
    push(K_EVAL, "collide_mem20_77", 8'h77);
    s = f_dma(8'hAB); s.st = 1'b1;
    step(s);
    push(K_ADDR, "stop_no_incr", 8'h21);
    step(f_eval(8'h21));
    push(K_EVAL, "stop_no_store", 8'h21);

    // Same-cycle read and write return the pre-write byte
    step(f_addr(8'h30, 1'b0));
    s = f_dma(8'h5C); s.re = 1'b1; s.sel = 3'd4;
    step(s);
    push(K_RDATA, "read_pre_write", 8'h30);

    // Reset in the middle of a DMA
    step(f_addr(8'h00, 1'b0));
    for (int i = 0; i < 100; i++) step(f_dma(8'(i) ^ 8'h5A));
    s = f_dma(8'hEE); s.rst = 1'b1;
    step(s);
    push(K_ADDR, "mid_dma_reset_addr", 8'h00);
    push(K_RDATA, "mid_dma_reset_rdata", 8'h00);
    for (int i = 0; i <= 100; i++) step(f_eval(8'(i)));
    push(K_EVAL, "reset_drops_write_100", 8'h64);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      s      = quiet();
      s.rst  = ($urandom_range(0, 99) == 0);
      s.en   = ($urandom_range(0, 3) != 0);
      s.st   = ($urandom_range(0, 9) == 0);
      s.we   = ($urandom_range(0, 4) == 0);
      s.re   = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0:       s.sel = 3'd3;
        1, 2:    s.sel = 3'd4;
        default: s.sel = 3'($urandom_range(0, 7));
      endcase
      s.wd   = 8'($urandom);
      s.dw   = ($urandom_range(0, 2) == 0);
      s.dd   = 8'($urandom);
      s.rend = ($urandom_range(0, 4) == 0);
      s.clr  = ($urandom_range(0, 19) == 0);
      s.ere  = ($urandom_range(0, 1) == 1);
      s.ea   = 8'($urandom);
      if (s.dw && s.we && s.sel == 3'd3) s.we = 1'b0;
      step(s);
    end

    repeat (3) step(quiet());
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
